// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder: reads a multiplexed 7-segment bus back into atomic multi-digit BCD frames.
// Optional feature: define SEG_ALT_GLYPHS_EN to also accept the alternate 6 / 7 / 9 glyphs.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   dout,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_LOCKED} state_t;

    // Result layout: {legal, blank, bcd nibble}.
    function automatic logic [5:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 6'b10_0000;
            7'b0110000: decode = 6'b10_0001;
            7'b1101101: decode = 6'b10_0010;
            7'b1111001: decode = 6'b10_0011;
            7'b0110011: decode = 6'b10_0100;
            7'b1011011: decode = 6'b10_0101;
            7'b1011111: decode = 6'b10_0110;
            7'b1110000: decode = 6'b10_0111;
            7'b1111111: decode = 6'b10_1000;
            7'b1111011: decode = 6'b10_1001;
            7'b0000000: decode = 6'b11_0000;
`ifdef SEG_ALT_GLYPHS_EN
            7'b0011111: decode = 6'b10_0110;
            7'b1110010: decode = 6'b10_0111;
            7'b1110011: decode = 6'b10_1001;
`endif
            default:    decode = 6'b00_0000;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [6:0]            seg_q;
    logic [DIGITS-1:0]     dig_q;
    logic [7:0]            cnt_q, cnt_d, mh_q, mh_d;
    logic [4*DIGITS-1:0]   sh_nib_q, sh_nib_d, dout_q, dout_d;
    logic [DIGITS-1:0]     sh_blank_q, sh_blank_d, blank_q, blank_d, mask_q, mask_d;
    logic                  pub_q, pub_d, frame_q, frame_d, err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [DIGITS-1:0]     dig_m1, seen;
    logic [5:0]            glyph;
    logic                  chg, one_hot, multi, commit, good, bad, mh_err, err_ev, done;

    // The arriving sample is compared with the registered one, so a pattern
    // registered at edge N matches from edge N+1 and commits at N+STABLE_CYCLES-1.
    always_comb begin
        chg = (seg != seg_q) || (dig != dig_q);
        dig_m1 = dig - DIGITS'(1);
        multi = (dig & dig_m1) != '0;
        one_hot = (dig != '0) && !multi;
        glyph = decode(seg);
        state_d = state_q;
        cnt_d = cnt_q;
        commit = 1'b0;
        if (!one_hot) begin
            state_d = S_WAIT;
            cnt_d = '0;
        end else if (chg) begin
            state_d = S_COUNT;
            cnt_d = 8'd1;
        end else if (state_q == S_COUNT) begin
            cnt_d = cnt_q + 8'd1;
            commit = cnt_d == SC;
            state_d = commit ? S_LOCKED : S_COUNT;
        end
        mh_d = !multi ? '0 : chg ? 8'd1 : (mh_q == SC ? SC : mh_q + 8'd1);
        mh_err = multi && mh_d == SC && mh_q != SC;
        good = commit && glyph[5];
        bad = commit && !glyph[5];
        err_ev = bad || mh_err;
        err_d = err_ev || (err_q && !clr);
        err_code_d = err_ev ? ((err_q && !clr) ? err_code_q : (bad ? 2'b01 : 2'b10))
                            : (clr ? 2'b00 : err_code_q);
        sh_nib_d = sh_nib_q;
        sh_blank_d = sh_blank_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (good && dig[i]) begin
                sh_nib_d[4*i +: 4] = glyph[3:0];
                sh_blank_d[i] = glyph[4];
            end
        end
        seen = mask_q | (good ? dig : '0);
        done = good && (seen == '1);
        mask_d = (done || clr) ? '0 : seen;
        pub_d = done;
        frame_d = pub_q;
        dout_d = pub_q ? sh_nib_q : dout_q;
        blank_d = pub_q ? sh_blank_q : blank_q;
    end

    // State, sample, shadow and published-frame registers; reset drops any partial frame at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT;
            seg_q      <= '0;
            dig_q      <= '0;
            cnt_q      <= '0;
            mh_q       <= '0;
            sh_nib_q   <= '0;
            sh_blank_q <= '0;
            mask_q     <= '0;
            pub_q      <= 1'b0;
            frame_q    <= 1'b0;
            dout_q     <= '0;
            blank_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            seg_q      <= seg;
            dig_q      <= dig;
            cnt_q      <= cnt_d;
            mh_q       <= mh_d;
            sh_nib_q   <= sh_nib_d;
            sh_blank_q <= sh_blank_d;
            mask_q     <= mask_d;
            pub_q      <= pub_d;
            frame_q    <= frame_d;
            dout_q     <= dout_d;
            blank_q    <= blank_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign dout = dout_q;
    assign blank = blank_q;
    assign frame = frame_q;
    assign err = err_q;
    assign err_code = err_code_q;
endmodule
